// File: rtl/cache_pkg.sv
// Shared types and line geometry for the data-cache miss-handling logic.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WB,
        RD,
        FILL
    } refill_state_t;

    localparam int unsigned WORDS_PER_LINE = 4;
    localparam int unsigned BADDR_W        = 28;
    localparam int unsigned OFFSET_W       = 2;

endpackage

// File: rtl/cache_line_buf.sv
// Four-word line assembly buffer: one word written per cycle at idx_i,
// all words visible in parallel.
module cache_line_buf
    import cache_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            we_i,
    input  logic [OFFSET_W-1:0]             idx_i,
    input  logic [WIDTH-1:0]                wdata_i,
    output logic [WORDS_PER_LINE*WIDTH-1:0] words_o
);

    logic [WIDTH-1:0] word_q [WORDS_PER_LINE];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < WORDS_PER_LINE; i++) begin
                word_q[i] <= '0;
            end
        end else if (we_i) begin
            word_q[idx_i] <= wdata_i;
        end
    end

    always_comb begin
        words_o = '0;
        for (int unsigned i = 0; i < WORDS_PER_LINE; i++) begin
            words_o[i*WIDTH +: WIDTH] = word_q[i];
        end
    end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss engine for the direct-mapped 4-word-line cache: optional dirty-victim
// writeback, then a word-by-word line fetch and a single-cycle array write.
module cache_refill_ctrl #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned BADDR_W = cache_pkg::BADDR_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 miss_req,
    input  logic [31:0]          miss_addr,
    input  logic                 victim_dirty,
    input  logic [BADDR_W-1:0]   victim_baddr,
    input  logic [4*WIDTH-1:0]   victim_data,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [31:0]          mem_addr,
    output logic [WIDTH-1:0]     mem_wdata,
    input  logic                 mem_ack,
    input  logic [WIDTH-1:0]     mem_rdata,
    output logic                 busy,
    output logic                 line_we,
    output logic [BADDR_W-1:0]   line_baddr,
    output logic [WIDTH-1:0]     line_d0,
    output logic [WIDTH-1:0]     line_d1,
    output logic [WIDTH-1:0]     line_d2,
    output logic [WIDTH-1:0]     line_d3,
    output logic [1:0]           word_sel,
    output logic                 refill_done
);

    import cache_pkg::*;

    refill_state_t                    state_q, state_d;
    logic [OFFSET_W-1:0]              cnt_q, cnt_d;
    logic [BADDR_W-1:0]               fill_baddr_q, fill_baddr_d;
    logic [BADDR_W-1:0]               victim_baddr_q, victim_baddr_d;
    logic [WORDS_PER_LINE*WIDTH-1:0]  victim_data_q, victim_data_d;
    logic [1:0]                       wsel_q, wsel_d;
    logic [WORDS_PER_LINE*WIDTH-1:0]  buf_words;
    logic                             buf_we;
    logic                             unused_addr_bits;

    assign unused_addr_bits = ^miss_addr[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            fill_baddr_q   <= '0;
            victim_baddr_q <= '0;
            victim_data_q  <= '0;
            wsel_q         <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            fill_baddr_q   <= fill_baddr_d;
            victim_baddr_q <= victim_baddr_d;
            victim_data_q  <= victim_data_d;
            wsel_q         <= wsel_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        fill_baddr_d   = fill_baddr_q;
        victim_baddr_d = victim_baddr_q;
        victim_data_d  = victim_data_q;
        wsel_d         = wsel_q;
        unique case (state_q)
            IDLE: begin
                if (miss_req) begin
                    fill_baddr_d   = miss_addr[31:OFFSET_W+2];
                    wsel_d         = miss_addr[3:2];
                    victim_baddr_d = victim_baddr;
                    victim_data_d  = victim_data;
                    cnt_d          = '0;
                    state_d        = victim_dirty ? WB : RD;
                end
            end
            WB: begin
                if (mem_ack) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                if (mem_ack) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory-side outputs decode only registered state, so mem_ack never
    // reaches mem_req/mem_addr combinationally.
    always_comb begin
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        line_we     = 1'b0;
        refill_done = 1'b0;
        busy        = (state_q != IDLE);
        unique case (state_q)
            WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {victim_baddr_q, cnt_q, 2'b00};
                mem_wdata = victim_data_q[cnt_q*WIDTH +: WIDTH];
            end
            RD: begin
                mem_req  = 1'b1;
                mem_addr = {fill_baddr_q, cnt_q, 2'b00};
            end
            FILL: begin
                line_we     = 1'b1;
                refill_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign buf_we = (state_q == RD) && mem_ack;

    cache_line_buf #(
        .WIDTH(WIDTH)
    ) u_line_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (buf_we),
        .idx_i   (cnt_q),
        .wdata_i (mem_rdata),
        .words_o (buf_words)
    );

    assign line_baddr = fill_baddr_q;
    assign word_sel   = wsel_q;
    assign line_d0    = buf_words[0*WIDTH +: WIDTH];
    assign line_d1    = buf_words[1*WIDTH +: WIDTH];
    assign line_d2    = buf_words[2*WIDTH +: WIDTH];
    assign line_d3    = buf_words[3*WIDTH +: WIDTH];

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: table of miss transactions against a
// wait-state memory model, plus reset and spurious-strobe sequences.
module tb_cache_refill_ctrl;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          miss_req = 1'b0;
    logic [31:0]   miss_addr = '0;
    logic          victim_dirty = 1'b0;
    logic [27:0]   victim_baddr = '0;
    logic [127:0]  victim_data = '0;
    logic          mem_req, mem_we;
    logic [31:0]   mem_addr, mem_wdata;
    logic          mem_ack;
    logic [31:0]   mem_rdata;
    logic          busy, line_we, refill_done;
    logic [27:0]   line_baddr;
    logic [31:0]   line_d0, line_d1, line_d2, line_d3;
    logic [1:0]    word_sel;

    always #5 clk = ~clk;

    cache_refill_ctrl #(.WIDTH(32), .BADDR_W(28)) dut (
        .clk(clk), .rst_n(rst_n), .miss_req(miss_req), .miss_addr(miss_addr),
        .victim_dirty(victim_dirty), .victim_baddr(victim_baddr), .victim_data(victim_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy), .line_we(line_we),
        .line_baddr(line_baddr), .line_d0(line_d0), .line_d1(line_d1), .line_d2(line_d2),
        .line_d3(line_d3), .word_sel(word_sel), .refill_done(refill_done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory model: each word is acked after wait_cfg idle cycles; read data
    // is rd_base plus the word index. Monitors track protocol properties.
    int          wait_cfg = 0;
    logic [31:0] rd_base  = '0;
    int          wcnt = 0;
    logic        ack_r = 1'b0;
    logic        spur = 1'b0;
    logic [31:0] rdata_r = '0;
    logic        prev_req = 1'b0;
    logic [31:0] prev_addr = '0;
    int          done_cnt = 0, glitch_cnt = 0, req_err = 0, wd_err = 0;
    logic [31:0] log_addr [$];
    logic        log_we   [$];
    logic [31:0] log_wd   [$];

    assign mem_ack   = ack_r | spur;
    assign mem_rdata = rdata_r;

    always @(negedge clk) begin
        if (mem_req && prev_req && (mem_addr != prev_addr) && !ack_r) glitch_cnt <= glitch_cnt + 1;
        if (rst_n && (mem_req !== (busy && !line_we))) req_err <= req_err + 1;
        if (refill_done) done_cnt <= done_cnt + 1;
        if (line_we !== refill_done) wd_err <= wd_err + 1;
        prev_req  <= mem_req;
        prev_addr <= mem_addr;
        if (mem_req && rst_n) begin
            if (wcnt == wait_cfg) begin
                ack_r   <= 1'b1;
                rdata_r <= rd_base + {30'b0, mem_addr[3:2]};
                wcnt    <= 0;
                log_addr.push_back(mem_addr);
                log_we.push_back(mem_we);
                log_wd.push_back(mem_wdata);
            end else begin
                ack_r <= 1'b0;
                wcnt  <= wcnt + 1;
            end
        end else begin
            ack_r <= 1'b0;
            wcnt  <= 0;
        end
    end

    typedef struct {
        logic [31:0]  addr;
        logic         dirty;
        logic [27:0]  vbaddr;
        logic [127:0] vdata;
        logic [31:0]  rbase;
        int           wait_c;
        int           exp_fill;
        logic [27:0]  exp_lbaddr;
        logic [1:0]   exp_wsel;
    } vec_t;

    vec_t vecs [4];

    task automatic run_miss(input vec_t v, input bit inject);
        int d0, g0, r0, w0, fill, nexp, j;
        bit found;
        logic [127:0] exp_line;
        logic [31:0]  ea;
        logic [1:0]   wi;
        d0 = done_cnt; g0 = glitch_cnt; r0 = req_err; w0 = wd_err;
        log_addr.delete(); log_we.delete(); log_wd.delete();
        wait_cfg = v.wait_c;
        rd_base  = v.rbase;
        @(negedge clk);
        miss_req = 1'b1; miss_addr = v.addr; victim_dirty = v.dirty;
        victim_baddr = v.vbaddr; victim_data = v.vdata;
        found = 0; fill = 0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (inject && k == 2) begin
                miss_req = 1'b1; miss_addr = 32'h5555_5550;
                victim_dirty = 1'b1; victim_baddr = 28'h111_1111;
            end else begin
                miss_req = 1'b0; victim_dirty = 1'b0;
            end
            if (k == 1) check("busy_rise", busy, 1);
            if (line_we) begin
                fill = k; found = 1;
                break;
            end
        end
        miss_req = 1'b0;
        if (!found) begin
            check("fill_timeout", 0, 1);
            return;
        end
        exp_line = {v.rbase + 32'd3, v.rbase + 32'd2, v.rbase + 32'd1, v.rbase};
        check("fill_cycle", fill, v.exp_fill);
        check("line_baddr", line_baddr, v.exp_lbaddr);
        check("refill_done", refill_done, 1);
        check("line_data", {line_d3, line_d2, line_d1, line_d0}, exp_line);
        @(negedge clk);
        check("busy_fall", busy, 0);
        check("word_sel", word_sel, v.exp_wsel);
        if (inject) begin
            spur = 1'b1;
            @(negedge clk);
            spur = 1'b0;
            repeat (2) @(negedge clk);
            check("spur_ack_idle", {busy, mem_req}, 0);
        end
        check("line_hold", {line_d3, line_d2, line_d1, line_d0}, exp_line);
        nexp = v.dirty ? 8 : 4;
        check("mem_count", log_addr.size(), nexp);
        for (int i = 0; i < nexp && i < log_addr.size(); i++) begin
            if (v.dirty && i < 4) begin
                wi = 2'(i);
                ea = {v.vbaddr, wi, 2'b00};
                check("wb_word", {log_addr[i], log_we[i], log_wd[i]},
                      {ea, 1'b1, v.vdata[i*32 +: 32]});
            end else begin
                j  = v.dirty ? i - 4 : i;
                wi = 2'(j);
                ea = {v.addr[31:4], wi, 2'b00};
                check("rd_word", {log_addr[i], log_we[i]}, {ea, 1'b0});
            end
        end
        check("done_pulses", done_cnt - d0, 1);
        check("addr_stable", glitch_cnt - g0, 0);
        check("req_held", req_err - r0, 0);
        check("we_done_sync", wd_err - w0, 0);
    endtask

    initial begin
        vec_t rv;
        vecs[0] = '{32'h0000_1238, 1'b0, 28'h0, 128'h0, 32'h0000_00A0, 0, 5, 28'h000_0123, 2'b10};
        vecs[1] = '{32'h0000_ABC4, 1'b1, 28'h000_0456,
                    {32'h44, 32'h33, 32'h22, 32'h11}, 32'h0000_00B0, 0, 9, 28'h000_0ABC, 2'b01};
        vecs[2] = '{32'hDEAD_BEEC, 1'b0, 28'h0, 128'h0, 32'h0000_00C0, 3, 17, 28'hDEA_DBEE, 2'b11};
        vecs[3] = '{32'h0000_0000, 1'b1, 28'hFFF_FFFF,
                    {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000},
                    32'hFFFF_FFF0, 1, 17, 28'h000_0000, 2'b00};

        #1;
        check("rst_ctrl", {mem_req, mem_we, line_we, refill_done, busy}, 0);
        check("rst_data", {mem_addr, mem_wdata, line_baddr, word_sel}, 0);
        check("rst_line", {line_d3, line_d2, line_d1, line_d0}, 0);
        #21 rst_n = 1'b1;

        for (int i = 0; i < 4; i++) run_miss(vecs[i], 1'b0);

        rv = '{32'h0000_3004, 1'b0, 28'h0, 128'h0, 32'h0000_00E0, 2, 13, 28'h000_0300, 2'b01};
        run_miss(rv, 1'b1);

        // Reset in RD after two read acks, then a fresh miss to the same block
        log_addr.delete(); log_we.delete(); log_wd.delete();
        wait_cfg = 0; rd_base = 32'h0000_00F0;
        @(negedge clk);
        miss_req = 1'b1; miss_addr = 32'h0000_200C; victim_dirty = 1'b0;
        @(negedge clk);
        miss_req = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_reset_addr", mem_addr, 32'h0000_2008);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ctrl", {mem_req, mem_we, line_we, refill_done, busy}, 0);
        check("mid_rst_data", {mem_addr, mem_wdata, line_baddr, word_sel}, 0);
        check("mid_rst_line", {line_d3, line_d2, line_d1, line_d0}, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        rv = '{32'h0000_200C, 1'b0, 28'h0, 128'h0, 32'h0000_00F0, 0, 5, 28'h000_0200, 2'b11};
        run_miss(rv, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
